// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous single-port memory between the CPU and a peripheral master.
// Each access runs IDLE -> ACCESS -> CAPTURE -> ACK. The CPU has priority, and a starvation counter bounds how long the peripheral can wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic [DATA_W-1:0] per_rdata,
  output logic              per_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_owner,
  output logic              busy
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACK} state_t;

  state_t           state;
  logic             l_we;
  logic [CNT_W-1:0] starve_cnt;
  logic             per_wins;

  // The peripheral wins when it is the only requester, or when the CPU has used up its allowance.
  assign per_wins = per_req && (!cpu_req || starve_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      l_we       <= 1'b0;
      starve_cnt <= '0;
      cpu_rdata  <= '0;
      per_rdata  <= '0;
      cpu_ack    <= 1'b0;
      per_ack    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      cpu_owner  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      per_ack <= 1'b0;
      case (state)
        IDLE: if (cpu_req || per_req) begin
          state     <= ACCESS;
          busy      <= 1'b1;
          cpu_owner <= !per_wins;
          l_we      <= per_wins ? per_we    : cpu_we;
          mem_we    <= per_wins ? per_we    : cpu_we;
          mem_addr  <= per_wins ? per_addr  : cpu_addr;
          mem_wdata <= per_wins ? per_wdata : cpu_wdata;
          if (per_wins)
            starve_cnt <= '0;
          else if (per_req && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
        ACCESS: begin
          state  <= CAPTURE;
          mem_we <= 1'b0;
        end
        CAPTURE: begin
          state     <= ACK;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (!l_we) begin
            if (cpu_owner) cpu_rdata <= mem_rdata;
            else           per_rdata <= mem_rdata;
          end
          if (cpu_owner) cpu_ack <= 1'b1;
          else           per_ack <= 1'b1;
        end
        ACK: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cpu_owner <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A transaction-level model tracks the age of the granted access and an expected memory image.
// Directed cases pin latency, grant order and reset abort; a random phase follows.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, per_req = 0, per_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, per_addr = 0, per_wdata = 0;
  logic [15:0] cpu_rdata, per_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, per_ack, mem_we, cpu_owner, busy;
  logic        poke_en = 0;
  logic [15:0] poke_addr = 0, poke_data = 0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_rdata(per_rdata), .per_ack(per_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_owner(cpu_owner), .busy(busy)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Physical memory attached to the DUT; the bench can preload words through the poke port
  logic [15:0] tmem [0:65535];
  bit          tval [0:65535];
  always @(posedge clk) begin
    if (poke_en) begin
      tmem[poke_addr] <= poke_data;
      tval[poke_addr] <= 1'b1;
    end else if (mem_we) begin
      tmem[mem_addr] <= mem_wdata;
      tval[mem_addr] <= 1'b1;
    end
    mem_rdata <= tval[mem_addr] ? tmem[mem_addr] : init_val(mem_addr);
  end

  // Reference model state: one in-flight transaction described by its age in cycles since the grant
  logic [15:0] mmem [0:65535];
  bit          mval [0:65535];
  int          age = 0, starve = 0;
  bit          t_cpu, t_we;
  logic [15:0] t_addr, t_wdata, e_crd, e_prd;

  function automatic logic [15:0] mrd(input logic [15:0] a);
    return mval[a] ? mmem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pw;
    if (poke_en) begin mmem[poke_addr] = poke_data; mval[poke_addr] = 1'b1; end
    if (age == 0) begin
      if (cpu_req || per_req) begin
        pw = per_req && (!cpu_req || starve == SM);
        if (pw) starve = 0;
        else if (per_req && starve < SM) starve++;
        t_cpu   = !pw;
        t_we    = pw ? per_we    : cpu_we;
        t_addr  = pw ? per_addr  : cpu_addr;
        t_wdata = pw ? per_wdata : cpu_wdata;
        age = 1;
      end
    end else begin
      if (age == 1 && t_we) begin mmem[t_addr] = t_wdata; mval[t_addr] = 1'b1; end
      if (age == 2 && !t_we) begin
        if (t_cpu) e_crd = mrd(t_addr);
        else       e_prd = mrd(t_addr);
      end
      age = (age == 3) ? 0 : age + 1;
    end
  endtask

  task automatic monitor();
    bit on_mem;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        age = 0; starve = 0; e_crd = 0; e_prd = 0;
      end else begin
        model_step();
        #1;
        if (!reset) begin
          on_mem = (age == 1 || age == 2);
          chk("m_mem_addr",  mem_addr,  on_mem ? t_addr  : 16'h0);
          chk("m_mem_wdata", mem_wdata, on_mem ? t_wdata : 16'h0);
          chk("m_mem_we",    mem_we,    age == 1 && t_we);
          chk("m_cpu_ack",   cpu_ack,   age == 3 && t_cpu);
          chk("m_per_ack",   per_ack,   age == 3 && !t_cpu);
          chk("m_cpu_owner", cpu_owner, age != 0 && t_cpu);
          chk("m_busy",      busy,      age != 0);
          chk("m_cpu_rdata", cpu_rdata, e_crd);
          chk("m_per_rdata", per_rdata, e_prd);
        end
      end
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    poke_en = 1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 0;
  endtask

  // One isolated transaction from an idle arbiter; reports the ack cycle and bus activity per cycle
  task automatic txn(input bit is_cpu, input bit we, input logic [15:0] a, input logic [15:0] d,
                     output int ack_cyc, output logic [15:0] addr_c1, output logic [2:0] we_c);
    ack_cyc = -1; addr_c1 = 16'hxxxx; we_c = 3'b000;
    if (is_cpu) begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    else        begin per_req = 1; per_we = we; per_addr = a; per_wdata = d; end
    for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
      @(negedge clk);
      if (k == 1) addr_c1 = mem_addr;
      if (k <= 3) we_c[k-1] = mem_we;
      if (cpu_ack || per_ack) begin
        ack_cyc = k;
        chk(is_cpu ? "txn_per_ack_quiet" : "txn_cpu_ack_quiet", is_cpu ? per_ack : cpu_ack, 1'b0);
      end
    end
    if (ack_cyc < 0) chk("txn_timeout", 0, 1);
    cpu_req = 0; per_req = 0;
    @(negedge clk);
  endtask

  task automatic rnd_cpu();
    cpu_req = 1; cpu_we = 1'($urandom_range(1));
    cpu_addr = 16'($urandom_range(31)); cpu_wdata = 16'($urandom);
  endtask

  task automatic rnd_per();
    per_req = 1; per_we = 1'($urandom_range(1));
    per_addr = 16'($urandom_range(31)); per_wdata = 16'($urandom);
  endtask

  initial begin
    int          ac, got_n, per_wait, acks[3];
    logic [15:0] a1;
    logic [2:0]  wc;
    bit          order[10];

    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_acks", {cpu_ack, per_ack}, 2'b00);
    chk("rst_rdata", {cpu_rdata, per_rdata}, 32'h0);
    reset = 0;
    @(negedge clk);

    // CPU read
    poke(16'h0010, 16'hBEEF);
    txn(1, 0, 16'h0010, 16'h0, ac, a1, wc);
    chk("t1_ack_cycle", ac, 3);
    chk("t1_mem_addr_c1", a1, 16'h0010);
    chk("t1_cpu_rdata", cpu_rdata, 16'hBEEF);

    // Peripheral write, then readback
    txn(0, 1, 16'h0020, 16'h1234, ac, a1, wc);
    chk("t2_ack_cycle", ac, 3);
    chk("t2_we_cycles", wc, 3'b001);
    txn(0, 0, 16'h0020, 16'h0, ac, a1, wc);
    chk("t2_per_rdata", per_rdata, 16'h1234);
    chk("t2_cpu_rdata_kept", cpu_rdata, 16'hBEEF);

    // Peripheral alone, three back-to-back reads
    per_req = 1; per_we = 0; per_addr = 16'h0020;
    got_n = 0;
    for (int k = 1; k <= 20 && got_n < 3; k++) begin
      @(negedge clk);
      if (per_ack) begin acks[got_n] = k; got_n++; end
    end
    per_req = 0;
    chk("t5_ack_count", got_n, 3);
    chk("t5_ack0", acks[0], 3);
    chk("t5_ack1", acks[1], 7);
    chk("t5_ack2", acks[2], 11);
    @(negedge clk);

    // Both masters requesting continuously
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    per_req = 1; per_we = 0; per_addr = 16'h0020;
    got_n = 0;
    for (int k = 1; k <= 80 && got_n < 10; k++) begin
      @(negedge clk);
      if (cpu_ack || per_ack) begin
        chk("t3_single_ack", cpu_ack ^ per_ack, 1'b1);
        order[got_n] = cpu_ack;
        got_n++;
      end
    end
    cpu_req = 0; per_req = 0;
    chk("t3_grant_count", got_n, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t3_grant%0d_is_cpu", i), order[i], (i % 5) != 4);
    @(negedge clk);

    // Reset asserted during the ACCESS cycle of a CPU write
    poke(16'h0030, 16'h1111);
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'hAAAA;
    @(posedge clk);
    #2;
    chk("t4_we_before_reset", mem_we, 1'b1);
    reset = 1;
    #1;
    chk("t4_we_async_drop", mem_we, 1'b0);
    chk("t4_addr_zero", mem_addr, 16'h0);
    chk("t4_busy_zero", busy, 1'b0);
    chk("t4_owner_zero", cpu_owner, 1'b0);
    cpu_req = 0;
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_no_ack", {cpu_ack, per_ack, busy}, 3'b000);
    end
    txn(1, 0, 16'h0030, 16'h0, ac, a1, wc);
    chk("t4_write_aborted", cpu_rdata, 16'h1111);

    // Random traffic from both masters
    per_wait = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (cpu_req && cpu_ack) begin
        if ($urandom_range(1) == 0) cpu_req = 0; else rnd_cpu();
      end else if (!cpu_req && $urandom_range(2) == 0) rnd_cpu();
      if (per_req && per_ack) begin
        chk("rnd_per_wait_bounded", per_wait <= 4 * SM + 8, 1'b1);
        per_wait = 0;
        if ($urandom_range(1) == 0) per_req = 0; else rnd_per();
      end else if (per_req) per_wait++;
      else if ($urandom_range(2) == 0) begin rnd_per(); per_wait = 0; end
    end
    cpu_req = 0; per_req = 0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
